// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control path: FSM states, operator
// codes and display constants.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_OP_PEND,
        ST_ENTER_B,
        ST_EXEC,
        ST_SHOW_RES,
        ST_ERROR
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [15:0] ERR_CODE_DEFAULT = 16'hEEEE;
    localparam int unsigned BCD_W            = 4;

endpackage

// File: rtl/calc_sequencer_if.sv
// Keyboard strobes, ALU handshake and display word of the calculator sequencer.
interface calc_sequencer_if #(
    parameter int W = 16
);
    logic         is_num;
    logic         is_op;
    logic         is_eq;
    logic [3:0]   num_val;
    logic [1:0]   op_val;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic         alu_start;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic         alu_err;
    logic [W-1:0] data_out_bcd;
    logic         busy;

    modport master (
        output is_num, is_op, is_eq, num_val, op_val, alu_done, alu_result, alu_err,
        input  alu_a, alu_b, alu_op, alu_start, data_out_bcd, busy
    );

    modport slave (
        input  is_num, is_op, is_eq, num_val, op_val, alu_done, alu_result, alu_err,
        output alu_a, alu_b, alu_op, alu_start, data_out_bcd, busy
    );
endinterface

// File: rtl/calc_sequencer_bcd_entry_reg.sv
// One BCD operand register: digit shift-in with digit-limit and no-leading-zero
// rules, synchronous clear (combinable with a shift) and parallel load.
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_shift,
    input  logic [BCD_W-1:0]          i_digit,
    input  logic                      i_load,
    input  logic [DIGITS*BCD_W-1:0]   i_load_val,
    output logic [DIGITS*BCD_W-1:0]   o_value
);
    localparam int W  = DIGITS * BCD_W;
    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  r_val, w_base_val, w_nxt_val;
    logic [CW-1:0] r_cnt, w_base_cnt, w_load_cnt, w_nxt_cnt;
    logic          w_accept;

    always_comb begin
        // A clear in the same cycle as a shift makes the digit the first one.
        w_base_val = i_clr ? '0 : r_val;
        w_base_cnt = i_clr ? '0 : r_cnt;
        w_accept   = i_shift && (i_digit <= 4'd9) && (w_base_cnt < CW'(DIGITS))
                     && !((i_digit == '0) && (w_base_val == '0));

        w_load_cnt = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i_load_val[i*BCD_W +: BCD_W] != '0) w_load_cnt = CW'(i + 1);
        end

        w_nxt_val = w_base_val;
        w_nxt_cnt = w_base_cnt;
        if (i_load) begin
            w_nxt_val = i_load_val;
            w_nxt_cnt = w_load_cnt;
        end else if (w_accept) begin
            w_nxt_val = {w_base_val[W-BCD_W-1:0], i_digit};
            w_nxt_cnt = w_base_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_val <= '0;
            r_cnt <= '0;
        end else begin
            r_val <= w_nxt_val;
            r_cnt <= w_nxt_cnt;
        end
    end

    assign o_value = r_val;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds BCD operands from key strobes, launches the
// ALU, supports chaining, timeout and an error state, and selects the display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int                  DIGITS      = 4,
    parameter int                  ALU_TIMEOUT = 255,
    parameter logic [4*DIGITS-1:0] ERR_CODE    = ERR_CODE_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    calc_sequencer_if.slave bus
);
    localparam int W  = BCD_W * DIGITS;
    localparam int TW = $clog2(ALU_TIMEOUT + 2);

    state_t        r_state, w_next;
    logic [1:0]    r_op, r_pend_op, w_op_nxt;
    logic          r_chain, w_chain_nxt;
    logic [TW-1:0] r_cnt;
    logic          r_start, r_busy;
    logic [W-1:0]  r_dout, w_a, w_b;
    logic          w_eq, w_op, w_num, w_done_ok, w_timeout;
    logic          w_launch, w_pend_load;
    logic          w_a_clr, w_a_shift, w_a_load, w_b_clr, w_b_shift;

    // Strobe priority: equals, then operator, then a valid digit.
    always_comb begin
        w_eq      = bus.is_eq;
        w_op      = bus.is_op && !bus.is_eq;
        w_num     = bus.is_num && !bus.is_op && !bus.is_eq && (bus.num_val <= 4'd9);
        w_done_ok = (r_state == ST_EXEC) && !r_start && bus.alu_done;
        w_timeout = (r_state == ST_EXEC) && !w_done_ok && (r_cnt == TW'(ALU_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_ENTER_A;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ENTER_A:  if (w_op) w_next = ST_OP_PEND;
            ST_OP_PEND:  if (w_num) w_next = ST_ENTER_B;
            ST_ENTER_B:  if (w_eq || w_op) w_next = ST_EXEC;
            ST_EXEC: begin
                if (w_done_ok) begin
                    if (bus.alu_err) w_next = ST_ERROR;
                    else             w_next = r_chain ? ST_OP_PEND : ST_SHOW_RES;
                end else if (w_timeout) begin
                    w_next = ST_ERROR;
                end
            end
            ST_SHOW_RES: begin
                if (w_eq)       w_next = ST_EXEC;
                else if (w_op)  w_next = ST_OP_PEND;
                else if (w_num) w_next = ST_ENTER_A;
            end
            ST_ERROR:    if (w_eq || w_op || w_num) w_next = ST_ENTER_A;
            default:     w_next = ST_ENTER_A;
        endcase
    end

    always_comb begin
        w_launch    = 1'b0;
        w_pend_load = 1'b0;
        w_a_clr     = 1'b0;
        w_a_shift   = 1'b0;
        w_a_load    = 1'b0;
        w_b_clr     = 1'b0;
        w_b_shift   = 1'b0;
        w_op_nxt    = r_op;
        w_chain_nxt = r_chain;
        case (r_state)
            ST_ENTER_A: begin
                w_a_shift = w_num;
                if (w_op) w_op_nxt = bus.op_val;
            end
            ST_OP_PEND: begin
                if (w_op) w_op_nxt = bus.op_val;
                w_b_clr   = w_num;
                w_b_shift = w_num;
            end
            ST_ENTER_B: begin
                if (w_eq) begin
                    w_launch = 1'b1;
                end else if (w_op) begin
                    w_launch    = 1'b1;
                    w_chain_nxt = 1'b1;
                    w_pend_load = 1'b1;
                end else begin
                    w_b_shift = w_num;
                end
            end
            ST_EXEC: begin
                if (w_done_ok && !bus.alu_err) begin
                    w_a_load = 1'b1;
                    if (r_chain) w_op_nxt = r_pend_op;
                end
                if (w_done_ok || w_timeout) w_chain_nxt = 1'b0;
            end
            ST_SHOW_RES: begin
                if (w_eq) begin
                    w_launch = 1'b1;
                end else if (w_op) begin
                    w_op_nxt = bus.op_val;
                end else if (w_num) begin
                    w_a_clr   = 1'b1;
                    w_a_shift = 1'b1;
                end
            end
            ST_ERROR: begin
                if (w_eq || w_op || w_num) begin
                    w_a_clr  = 1'b1;
                    w_b_clr  = 1'b1;
                    w_op_nxt = OP_ADD;
                end
                w_a_shift = w_num;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op      <= OP_ADD;
            r_pend_op <= OP_ADD;
            r_chain   <= 1'b0;
            r_cnt     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_op    <= w_op_nxt;
            r_chain <= w_chain_nxt;
            r_start <= w_launch;
            r_busy  <= (w_next == ST_EXEC);
            if (w_pend_load) r_pend_op <= bus.op_val;
            if (w_launch)                 r_cnt <= '0;
            else if (r_state == ST_EXEC)  r_cnt <= r_cnt + 1'b1;
            case (r_state)
                ST_ENTER_B: r_dout <= w_b;
                ST_EXEC:    r_dout <= r_dout;
                ST_ERROR:   r_dout <= ERR_CODE;
                default:    r_dout <= w_a;
            endcase
        end
    end

    bcd_entry_reg #(.DIGITS(DIGITS)) u_opnd_a (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_a_clr),
        .i_shift   (w_a_shift),
        .i_digit   (bus.num_val),
        .i_load    (w_a_load),
        .i_load_val(bus.alu_result),
        .o_value   (w_a)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_opnd_b (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_b_clr),
        .i_shift   (w_b_shift),
        .i_digit   (bus.num_val),
        .i_load    (1'b0),
        .i_load_val('0),
        .o_value   (w_b)
    );

    assign bus.alu_a        = w_a;
    assign bus.alu_b        = w_b;
    assign bus.alu_op       = r_op;
    assign bus.alu_start    = r_start;
    assign bus.busy         = r_busy;
    assign bus.data_out_bcd = r_dout;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM of the calculator, sitting between `keyboard` and the arithmetic datapath in place of the `PassThrough` stage. It consumes the keyboard's one-cycle decode strobes (`is_num`, `is_op`, `is_eq`) and builds two 4-digit BCD operands and an operator from them. It launches the external ALU with a start/done handshake and selects the 16-bit BCD word shown by `display_out`. It supports operation chaining (result becomes operand A), an ALU timeout, and an error state.

## Interface
Parameters:
- `DIGITS`, 4: BCD digits per operand; operand width is 4*DIGITS.
- `ALU_TIMEOUT`, 255: cycles to wait for `alu_done` before entering ERROR.
- `ERR_CODE`, 16'hEEEE: display word shown in ERROR.

Ports:
- `clk` input 1: logic clock (`clk_logica` domain); the block has one clock.
- `rst` input 1: reset, synchronous and active-low.
- `is_num` input 1: one-cycle strobe; `num_val` is valid.
- `is_op` input 1: one-cycle strobe; `op_val` is valid.
- `is_eq` input 1: one-cycle strobe for the equals key.
- `num_val` input 4: digit 0–9. Values 10–15 are ignored.
- `op_val` input 2: operator code; 0 add, 1 sub, 2 mul, 3 div.
- `alu_a` output 16: operand A in BCD, held stable while busy.
- `alu_b` output 16: operand B in BCD, held stable while busy.
- `alu_op` output 2: latched operator.
- `alu_start` output 1: one-cycle launch pulse.
- `alu_done` input 1: one-cycle completion pulse.
- `alu_result` input 16: BCD result, valid when `alu_done` is high.
- `alu_err` input 1: qualifies `alu_done` (overflow or divide by zero).
- `data_out_bcd` output 16: word sent to the display.
- `busy` output 1: high in EXEC.

## Operation
States: ENTER_A, OP_PEND, ENTER_B, EXEC, SHOW_RES, ERROR. Reset enters ENTER_A.

Strobe priority: if strobes coincide, `is_eq` wins over `is_op`, which wins over `is_num`. Only one strobe is acted on per cycle.

Digit entry:
- The operand shifts left one digit and takes `num_val` into the low nibble: `opnd <= {opnd[11:0], num_val}`.
- A digit is ignored once the operand holds DIGITS significant digits.
- A digit is ignored if it is 0 and the operand is still 0, so there are no leading zeros.

Transitions:
- ENTER_A:
  - `is_num` shifts the digit into A.
  - `is_op` latches the operator and goes to OP_PEND.
  - `is_eq` is ignored.
- OP_PEND:
  - `is_op` replaces the latched operator.
  - `is_num` clears B, shifts the digit into B, and goes to ENTER_B.
  - `is_eq` is ignored.
- ENTER_B:
  - `is_num` shifts the digit into B.
  - `is_eq` launches the ALU and goes to EXEC.
  - `is_op` launches the ALU and sets a `chain` flag with the new operator held pending.
- EXEC:
  - All strobes are dropped.
  - `alu_done` with `alu_err`=0 loads A with `alu_result`.
  - If `chain` is set, the pending operator is latched and the state goes to OP_PEND; otherwise it goes to SHOW_RES.
  - `alu_done` with `alu_err`=1 goes to ERROR.
  - If the timeout counter reaches ALU_TIMEOUT, the state goes to ERROR.
- SHOW_RES:
  - `is_op` latches the operator and goes to OP_PEND (A keeps the result).
  - `is_num` clears A, shifts the digit into A, and goes to ENTER_A.
  - `is_eq` re-executes with the same B and operator.
- ERROR:
  - Any strobe clears A, B and the operator and goes to ENTER_A.
  - If that strobe is `is_num`, the digit becomes the first digit of A.

Display select:
- ENTER_A and SHOW_RES show A.
- OP_PEND shows A.
- ENTER_B shows B.
- EXEC shows the last displayed word.
- ERROR shows ERR_CODE.

## Timing
- All outputs are registered. A strobe at edge N is reflected on `data_out_bcd` after edge N+1.
- `alu_start` is high exactly for the first cycle of EXEC.
- `alu_a`, `alu_b` and `alu_op` are valid from that cycle until the cycle after `alu_done`.
- `alu_done` is accepted only in EXEC. A `alu_done` arriving in the same cycle as `alu_start` is ignored.
- The timeout counter:
  - clears on EXEC entry;
  - increments every EXEC cycle;
  - a counter equal to ALU_TIMEOUT with no `alu_done` that cycle moves the state to ERROR on the next edge;
  - `alu_done` and the timeout in the same cycle: `alu_done` wins.
- Reset values (`rst`=0 at an edge): state ENTER_A, `alu_a`=`alu_b`=0, `alu_op`=0, `alu_start`=0, `busy`=0, `data_out_bcd`=0, `chain`=0, counter 0.
- Reset during EXEC aborts the operation. A later `alu_done` is ignored because the state is ENTER_A.

## Structure
- Shared package `calc_pkg` holds:
  - the state encoding;
  - the operator codes OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the ERR_CODE default;
  - the BCD digit width constant.
- Sub-module `bcd_entry_reg` implements one operand register, instantiated twice (A and B):
  - shift-in of a digit, synchronous clear and parallel load;
  - the digit-limit and leading-zero rules;
  - its own digit counter.

## Test plan
- Enter keys 1,2,+,3,4,= with the ALU model returning 16'h0046 → `alu_start` pulses once with A=16'h0012, B=16'h0034, op=0; `data_out_bcd` becomes 16'h0046.
- Enter keys 9,8,7,6,5 → A=16'h9876; the fifth digit is ignored. Leading 0,0,7 → A=16'h0007 with only one significant digit counted.
- Chain 5,+,3,*,2,= with the model computing results → the first result 16'h0008 loads A; the second launch has op=2 and B=16'h0002; the display shows 16'h0016.
- Enter 8,/,0,= with `alu_err`=1 → state ERROR, display 16'hEEEE; the next key 4 gives display 16'h0004 in ENTER_A.
- Start an operation with the model never asserting done → ERROR exactly ALU_TIMEOUT+1 cycles after `alu_start`. Separately, drive `rst`=0 mid-EXEC followed by `alu_done` → all outputs zero and no state change.
- Assert `is_num` and `is_eq` together in ENTER_B → only equals acts: `alu_start` fires and B is unchanged.
